// File: rtl/rename_if.sv
// rename_if: decode -> rename -> issue_queue bundle, including wake-up and commit-free ports
interface rename_if #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int ARN_BITS     = 5,
  parameter int MAX_OPERANDS = 3,
  parameter int FU_COUNT     = 4
);
  logic                                            in_valid;
  logic                                            in_ready;
  logic [INST_ID_BITS-1:0]                         in_inst_id;
  logic [31:0]                                     in_raw_instr;
  logic [63:0]                                     in_pc;
  logic [MAX_OPERANDS-1:0]                         src_valid;
  logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]           src_arn;
  logic [MAX_OPERANDS-1:0]                         dst_valid;
  logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]           dst_arn;
  logic                                            inst_valid;
  logic                                            queue_ready;
  logic [INST_ID_BITS-1:0]                         inst_id;
  logic [31:0]                                     raw_instr;
  logic [63:0]                                     instr_pc;
  logic [MAX_OPERANDS-1:0]                         prn_input_valid;
  logic [MAX_OPERANDS-1:0]                         prn_input_ready;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]           prn_input;
  logic [MAX_OPERANDS-1:0]                         prn_output_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]           prn_output;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]           old_prn;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]           set_prn_ready;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn;
  logic [MAX_OPERANDS-1:0]                         free_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]           free_prn;
  modport master (
    output in_valid, in_inst_id, in_raw_instr, in_pc, src_valid, src_arn, dst_valid, dst_arn,
           queue_ready, set_prn_ready, set_prn, free_valid, free_prn,
    input  in_ready, inst_valid, inst_id, raw_instr, instr_pc, prn_input_valid, prn_input_ready,
           prn_input, prn_output_valid, prn_output, old_prn
  );
  modport slave (
    input  in_valid, in_inst_id, in_raw_instr, in_pc, src_valid, src_arn, dst_valid, dst_arn,
           queue_ready, set_prn_ready, set_prn, free_valid, free_prn,
    output in_ready, inst_valid, inst_id, raw_instr, instr_pc, prn_input_valid, prn_input_ready,
           prn_input, prn_output_valid, prn_output, old_prn
  );
endinterface

// File: rtl/rename_stage.sv
// rename_stage: RAT lookup, circular free-list allocation and ready tracking, one instruction per cycle
module rename_stage #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int ARN_BITS     = 5,
  parameter int MAX_OPERANDS = 3,
  parameter int FU_COUNT     = 4,
  parameter int ZERO_ARN     = 31
) (
  input logic   clk,
  input logic   rst,
  rename_if.slave io
);
  localparam int NUM_PRN   = 2**PRN_BITS;
  localparam int ARCH_REGS = 2**ARN_BITS;
  localparam int FL_SIZE   = NUM_PRN - ARCH_REGS;
  localparam int FL_BITS   = $clog2(FL_SIZE);
  localparam int CW        = FL_BITS + 2;
  logic [PRN_BITS-1:0]                   r_rat [ARCH_REGS];
  logic [PRN_BITS-1:0]                   r_fl [FL_SIZE];
  logic [NUM_PRN-1:0]                    r_ready;
  logic [FL_BITS-1:0]                    r_head, r_tail;
  logic [CW-1:0]                         r_count;
  logic                                  r_valid;
  logic [INST_ID_BITS-1:0]               r_id;
  logic [31:0]                           r_raw;
  logic [63:0]                           r_pc;
  logic [MAX_OPERANDS-1:0]               r_in_valid, r_in_ready, r_out_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] r_in_prn, r_out_prn, r_old_prn;
  logic [NUM_PRN-1:0]                    w_set;
  logic [MAX_OPERANDS-1:0]               w_alloc, w_src_rdy, w_held_hit;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] w_src_prn, w_new, w_old;
  logic [MAX_OPERANDS-1:0][FL_BITS-1:0]  w_pop_idx, w_push_idx;
  logic [CW-1:0]                         w_need, w_pushes, w_cnt_next;
  logic                                  w_in_ready, w_acc;
  always_comb begin
    w_set = '0;
    for (int f = 0; f < FU_COUNT; f++)
      for (int o = 0; o < MAX_OPERANDS; o++)
        if (io.set_prn_ready[f][o]) w_set[io.set_prn[f][o]] = 1'b1;
    w_need   = '0;
    w_pushes = '0;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      w_alloc[i]    = io.dst_valid[i] && io.dst_arn[i] != ARN_BITS'(ZERO_ARN);
      w_pop_idx[i]  = r_head + FL_BITS'(w_need);
      w_push_idx[i] = r_tail + FL_BITS'(w_pushes);
      w_new[i]      = w_alloc[i] ? r_fl[w_pop_idx[i]] : '0;
      w_old[i]      = w_alloc[i] ? r_rat[io.dst_arn[i]] : '0;
      w_src_prn[i]  = io.src_valid[i] ? r_rat[io.src_arn[i]] : '0;
      // Same-cycle wake-up bypass so a broadcast coinciding with lookup is not missed
      w_src_rdy[i]  = io.src_valid[i] && (io.src_arn[i] == ARN_BITS'(ZERO_ARN) ||
                      r_ready[w_src_prn[i]] || w_set[w_src_prn[i]]);
      w_held_hit[i] = r_in_valid[i] && w_set[r_in_prn[i]];
      w_need        = w_need + CW'(w_alloc[i]);
      w_pushes      = w_pushes + CW'(io.free_valid[i]);
    end
    w_in_ready = (!r_valid || io.queue_ready) && r_count >= w_need;
    w_acc      = io.in_valid && w_in_ready;
    w_cnt_next = r_count + w_pushes - (w_acc ? w_need : '0);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < ARCH_REGS; a++) r_rat[a] <= PRN_BITS'(a);
      for (int k = 0; k < FL_SIZE; k++) r_fl[k] <= PRN_BITS'(ARCH_REGS + k);
      r_ready     <= '1;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= CW'(FL_SIZE);
      r_valid     <= 1'b0;
      r_id        <= '0;
      r_raw       <= '0;
      r_pc        <= '0;
      r_in_valid  <= '0;
      r_in_ready  <= '0;
      r_in_prn    <= '0;
      r_out_valid <= '0;
      r_out_prn   <= '0;
      r_old_prn   <= '0;
    end else begin
      r_ready    <= r_ready | w_set;
      r_count    <= w_cnt_next;
      r_tail     <= r_tail + FL_BITS'(w_pushes);
      r_in_ready <= r_in_ready | w_held_hit;
      for (int i = 0; i < MAX_OPERANDS; i++)
        if (io.free_valid[i]) r_fl[w_push_idx[i]] <= io.free_prn[i];
      if (w_acc) begin
        r_head <= r_head + FL_BITS'(w_need);
        // Later slots overwrite earlier ones; allocation clears override wake-up sets
        for (int i = 0; i < MAX_OPERANDS; i++)
          if (w_alloc[i]) begin
            r_rat[io.dst_arn[i]] <= w_new[i];
            r_ready[w_new[i]]    <= 1'b0;
          end
        r_valid     <= 1'b1;
        r_id        <= io.in_inst_id;
        r_raw       <= io.in_raw_instr;
        r_pc        <= io.in_pc;
        r_in_valid  <= io.src_valid;
        r_in_ready  <= w_src_rdy;
        r_in_prn    <= w_src_prn;
        r_out_valid <= w_alloc;
        r_out_prn   <= w_new;
        r_old_prn   <= w_old;
      end else if (io.queue_ready) r_valid <= 1'b0;
    end
  end
  assert property (@(posedge clk) disable iff (!rst) w_cnt_next <= CW'(FL_SIZE));
  assign io.in_ready         = w_in_ready;
  assign io.inst_valid       = r_valid;
  assign io.inst_id          = r_id;
  assign io.raw_instr        = r_raw;
  assign io.instr_pc         = r_pc;
  assign io.prn_input_valid  = r_in_valid;
  assign io.prn_input_ready  = r_in_ready | w_held_hit;
  assign io.prn_input        = r_in_prn;
  assign io.prn_output_valid = r_out_valid;
  assign io.prn_output       = r_out_prn;
  assign io.old_prn          = r_old_prn;
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: directed vectors with hand-computed expectations for rename_stage
module tb_rename_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  rename_if bus();
  rename_stage dut (.clk(clk), .rst(rst), .io(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [5:0] id, input logic [2:0] sv, input logic [4:0] s0, input logic [4:0] s1,
                     input logic [2:0] dv, input logic [4:0] d0, input logic [4:0] d1);
    bus.in_valid     = 1'b1;
    bus.in_inst_id   = id;
    bus.in_raw_instr = {26'h0, id};
    bus.in_pc        = 64'h1000 + 64'(id) * 4;
    bus.src_valid    = sv;
    bus.src_arn      = {5'd0, s1, s0};
    bus.dst_valid    = dv;
    bus.dst_arn      = {5'd0, d1, d0};
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_inst_id = '0; bus.in_raw_instr = '0; bus.in_pc = '0;
    bus.src_valid = '0; bus.src_arn = '0; bus.dst_valid = '0; bus.dst_arn = '0;
    bus.queue_ready = 1'b1; bus.set_prn_ready = '0; bus.set_prn = '0;
    bus.free_valid = '0; bus.free_prn = '0;
    #12;
    chk("rst_inst_valid", bus.inst_valid, 0);
    chk("rst_prn_output", bus.prn_output, 0);
    chk("rst_count", dut.r_count, 32);
    rst = 1'b1;
    put(1, 3'b011, 1, 2, 3'b001, 3, 0);
    step;
    chk("a_valid", bus.inst_valid, 1);
    chk("a_id", bus.inst_id, 1);
    chk("a_pc", bus.instr_pc, 64'h1004);
    chk("a_src0", bus.prn_input[0], 1);
    chk("a_src1", bus.prn_input[1], 2);
    chk("a_rdy", bus.prn_input_ready, 3'b011);
    chk("a_dst", bus.prn_output[0], 32);
    chk("a_dstv", bus.prn_output_valid, 3'b001);
    chk("a_old", bus.old_prn[0], 3);
    chk("a_count", dut.r_count, 31);
    put(2, 3'b011, 3, 3, 3'b001, 4, 0);
    step;
    chk("b_src0", bus.prn_input[0], 32);
    chk("b_src1", bus.prn_input[1], 32);
    chk("b_rdy", bus.prn_input_ready, 3'b000);
    chk("b_dst", bus.prn_output[0], 33);
    chk("b_old", bus.old_prn[0], 4);
    bus.in_valid = 1'b0;
    bus.queue_ready = 1'b0;
    bus.set_prn[2][1] = 6'd32;
    bus.set_prn_ready[2][1] = 1'b1;
    #1;
    chk("bc_comb_rdy", bus.prn_input_ready, 3'b011);
    step;
    bus.set_prn_ready = '0;
    bus.set_prn = '0;
    #1;
    chk("bc_reg_rdy", bus.prn_input_ready, 3'b011);
    chk("bc_held_id", bus.inst_id, 2);
    put(3, 3'b011, 4, 1, 3'b001, 5, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", bus.in_ready, 0);
      step;
      chk("stall_id", bus.inst_id, 2);
      chk("stall_count", dut.r_count, 30);
    end
    chk("stall_rat5", dut.r_rat[5], 5);
    bus.queue_ready = 1'b1;
    #1;
    chk("release_in_ready", bus.in_ready, 1);
    step;
    chk("c_id", bus.inst_id, 3);
    chk("c_src0", bus.prn_input[0], 33);
    chk("c_src1", bus.prn_input[1], 1);
    chk("c_rdy", bus.prn_input_ready, 3'b010);
    chk("c_dst", bus.prn_output[0], 34);
    chk("c_old", bus.old_prn[0], 5);
    chk("c_count", dut.r_count, 29);
    for (int k = 0; k < 29; k++) begin
      put(6'(10 + k), 3'b000, 0, 0, 3'b001, 6, 0);
      step;
    end
    chk("ex_last_dst", bus.prn_output[0], 63);
    chk("ex_count", dut.r_count, 0);
    put(40, 3'b000, 0, 0, 3'b001, 7, 0);
    #1;
    chk("empty_in_ready", bus.in_ready, 0);
    put(41, 3'b001, 2, 0, 3'b000, 0, 0);
    #1;
    chk("srconly_in_ready", bus.in_ready, 1);
    step;
    chk("srconly_valid", bus.inst_valid, 1);
    chk("srconly_dstv", bus.prn_output_valid, 0);
    put(42, 3'b000, 0, 0, 3'b001, 7, 0);
    bus.free_valid = 3'b001;
    bus.free_prn[0] = 6'd3;
    #1;
    chk("push_same_cycle_in_ready", bus.in_ready, 0);
    step;
    bus.free_valid = '0;
    #1;
    chk("push_drop_valid", bus.inst_valid, 0);
    chk("push_count", dut.r_count, 1);
    chk("push_in_ready", bus.in_ready, 1);
    step;
    chk("freed_dst", bus.prn_output[0], 3);
    chk("freed_old", bus.old_prn[0], 7);
    chk("freed_count", dut.r_count, 0);
    put(43, 3'b001, 31, 0, 3'b001, 31, 0);
    #1;
    chk("zero_in_ready", bus.in_ready, 1);
    step;
    chk("zero_dstv", bus.prn_output_valid, 0);
    chk("zero_dst", bus.prn_output, 0);
    chk("zero_src", bus.prn_input[0], 31);
    chk("zero_rdy", bus.prn_input_ready, 3'b001);
    chk("zero_count", dut.r_count, 0);
    bus.in_valid = 1'b0;
    bus.free_valid = 3'b011;
    bus.free_prn[0] = 6'd10;
    bus.free_prn[1] = 6'd11;
    step;
    bus.free_valid = '0;
    chk("free2_count", dut.r_count, 2);
    put(44, 3'b000, 0, 0, 3'b011, 5, 5);
    step;
    chk("dup_dst0", bus.prn_output[0], 10);
    chk("dup_dst1", bus.prn_output[1], 11);
    chk("dup_old0", bus.old_prn[0], 34);
    chk("dup_old1", bus.old_prn[1], 34);
    chk("dup_rat5", dut.r_rat[5], 11);
    bus.in_valid = 1'b0;
    bus.free_valid = 3'b001;
    bus.free_prn[0] = 6'd12;
    step;
    bus.free_valid = '0;
    put(45, 3'b000, 0, 0, 3'b001, 8, 0);
    bus.set_prn[0][0] = 6'd12;
    bus.set_prn_ready[0][0] = 1'b1;
    step;
    bus.set_prn_ready = '0;
    chk("clr_beats_set_dst", bus.prn_output[0], 12);
    chk("clr_beats_set_rdy", dut.r_ready[12], 0);
    bus.queue_ready = 1'b0;
    put(46, 3'b000, 0, 0, 3'b001, 9, 0);
    #1;
    chk("pre_rst_stall", bus.in_ready, 0);
    chk("pre_rst_valid", bus.inst_valid, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", bus.inst_valid, 0);
    chk("mid_rst_count", dut.r_count, 32);
    chk("mid_rst_rat5", dut.r_rat[5], 5);
    chk("mid_rst_rat8", dut.r_rat[8], 8);
    chk("mid_rst_dst", bus.prn_output, 0);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    step;
    chk("post_rst_valid", bus.inst_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Register renamer directly upstream of issue_queue.
- Maps architectural source/destination registers to physical register numbers (PRNs) via a RAT, allocates destinations from a circular free list, and tracks per-PRN readiness in a ready table.
- Presents one renamed instruction per cycle to the issue queue through a one-entry output register; commit returns retired PRNs to the free list.

Parameters:
- INST_ID_BITS, 6, instruction id width.
- PRN_BITS, 6, PRN width; NUM_PRN = 2**PRN_BITS.
- ARN_BITS, 5, architectural register number width; ARCH_REGS = 2**ARN_BITS.
- MAX_OPERANDS, 3, source and destination slots per instruction.
- FU_COUNT, 4, wake-up broadcast ports.
- ZERO_ARN, 31, zero register: never renamed, always ready.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- in_valid  in  1  decoded instruction offered.
- in_ready  out  1  stage accepts this cycle.
- in_inst_id  in  INST_ID_BITS  instruction id, passed through.
- in_raw_instr  in  32  raw instruction, passed through.
- in_pc  in  64  PC, passed through.
- src_valid[MAX_OPERANDS]  in  1  source slot used.
- src_arn[MAX_OPERANDS]  in  ARN_BITS  source architectural register.
- dst_valid[MAX_OPERANDS]  in  1  destination slot used.
- dst_arn[MAX_OPERANDS]  in  ARN_BITS  destination architectural register.
- inst_valid  out  1  to issue_queue.
- queue_ready  in  1  from issue_queue.
- inst_id, raw_instr, instr_pc  out  INST_ID_BITS/32/64  registered pass-through.
- prn_input_valid[MAX_OPERANDS]  out  1
- prn_input_ready[MAX_OPERANDS]  out  1
- prn_input[MAX_OPERANDS]  out  PRN_BITS
- prn_output_valid[MAX_OPERANDS]  out  1
- prn_output[MAX_OPERANDS]  out  PRN_BITS
- old_prn[MAX_OPERANDS]  out  PRN_BITS  previous mapping of each destination; the ROB frees it at commit.
- set_prn_ready[FU_COUNT][MAX_OPERANDS]  in  1  wake-up broadcast.
- set_prn[FU_COUNT][MAX_OPERANDS]  in  PRN_BITS  wake-up broadcast.
- free_valid[MAX_OPERANDS]  in  1  commit returns PRN.
- free_prn[MAX_OPERANDS]  in  PRN_BITS  PRN returned by commit.

Behaviour:
Reset (rst=0, async):
- RAT[a]=a.
- All ready bits = 1.
- Free list holds PRNs ARCH_REGS..NUM_PRN-1 in ascending order; head=0, count=NUM_PRN-ARCH_REGS (32).
- inst_valid=0; all other outputs 0.

Allocation demand:
- need = number of dst slots with dst_valid=1 and dst_arn!=ZERO_ARN.

Handshake:
- in_ready = (!inst_valid || queue_ready) && (count >= need).
- in_ready must not depend on in_valid.
- Accept = in_valid && in_ready.
- Output register: loaded on accept, cleared on queue_ready without accept, held otherwise.

Latency:
- One cycle from accept to inst_valid=1.

Renaming (same cycle as accept):
- Sources: read RAT before this instruction's own destination updates.
- prn_input_valid = src_valid.
- Source arn ZERO_ARN → prn_input = RAT[ZERO_ARN], ready = 1.
- Destinations: slots popped in index order from the free-list head.
- old_prn = RAT[dst_arn], read from the pre-update RAT.
- RAT[dst_arn] ← new PRN.
- Ready bit of each allocated PRN cleared.
- Duplicate dst_arn within one instruction: highest slot index wins the RAT; every slot still allocates.
- Unused or zero-register destination: prn_output_valid=0, prn_output=0.

Ready tracking:
- Any asserted set_prn_ready sets the ready bit of its set_prn.
- A source looked up in the cycle its PRN is broadcast reads ready=1 (bypass).
- Held output register: the ready bit of a matching prn_input is set on broadcast.
- prn_input_ready is driven as the registered ready OR a same-cycle broadcast match, so a wake-up coincident with the issue_queue insert is never lost.
- A clear from allocation beats a set for the same PRN in the same cycle.

Free list:
- Circular buffer of NUM_PRN-ARCH_REGS entries; head/tail wrap modulo size.
- Same-cycle pop (≤MAX_OPERANDS) and push (≤MAX_OPERANDS): count updates by pushes − pops.
- Pushed PRNs are not allocatable before the next cycle.
- Push when count would exceed capacity is illegal; simulation assertion fires.

Reset mid-operation:
- Asynchronously returns all state to reset values.
- Any held output instruction is dropped.

Test Plan:
- Reset, then rename src x1,x2, dst x3 → next cycle: inst_valid=1, prn_input={1,2}, ready={1,1}; prn_output[0]=32, old_prn[0]=3; count 32→31.
- Back-to-back: x3=x1+x2, then x4=x3+x3 → second: prn_input={32,32}, ready=0, prn_output=33.
- Broadcast set_prn=32 in the cycle the second instruction is held → prn_input_ready=1 combinationally that cycle; registered thereafter.
- queue_ready=0 for 3 cycles with in_valid=1 → outputs stable, in_ready=0, RAT and free list unchanged; transfer the cycle queue_ready rises.
- Issue 32 single-dst instructions with no frees → count=0, in_ready=0 for the next dst instruction; a src-only instruction still accepted; one free_valid push → stall releases the following cycle, allocating the freed PRN.
- dst x31 → prn_output_valid=0, no pop. Duplicate dst x5 in slots 0,1 → RAT[5]=slot-1 PRN. Assert rst mid-stall → inst_valid=0 immediately, count=32, RAT identity.
